// File: rtl/one2three_pkg.sv
// Shared types for the triple-redundant frame transmitter.
package one2three_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
    localparam int ID_W  = 4;
    localparam int NCOPY = 3;
endpackage

// File: rtl/one2three_if.sv
// Byte-stream bundle: frame input side, GMII-style transmit side, drop flag.
interface one2three_if;
    logic       en_in;
    logic [7:0] data_in;
    logic       in_ready;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       dropped;

    modport master (output en_in, output data_in,
                    input in_ready, input tx_en, input tx_data, input dropped);
    modport slave  (input en_in, input data_in,
                    output in_ready, output tx_en, output tx_data, output dropped);
endinterface

// File: rtl/one2three_frame_buf.sv
// Simple dual-port frame store, one write and one read port, 1-cycle registered read.
// No reset on the array or read register so it maps onto block RAM.
module frame_buf #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    output logic [7:0]    rd
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/one2three.sv
// Buffers one frame then transmits it three times, stamping copy ID 1..3 into byte WHEREISID.
// First output byte two cycles after the frame ends; new frames refused (dropped) while busy.
module one2three #(
    parameter int WHEREISID = 22,
    parameter int MAXLEN    = 4096,
    parameter int GAP       = 12
) (
    input  logic        clk,
    input  logic        rst,
    one2three_if.slave  bus
);
    import one2three_pkg::*;

    localparam int AW = $clog2(MAXLEN);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] MAXL     = CW'(MAXLEN);
    localparam logic [CW-1:0] ID_POS   = CW'(WHEREISID);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    state_t          state;
    logic [CW-1:0]   len;
    logic [CW-1:0]   idx;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      copy;
    logic [GW-1:0]   gcnt;
    logic            en_prev;
    logic            ready_prev;
    logic            in_ready_q;
    logic            tx_en_q;
    logic [7:0]      tx_data_q;
    logic [7:0]      q;
    logic            rise;
    logic            accept;
    logic            we;
    logic [AW-1:0]   wa;
    logic [ID_W-1:0] id;

    assign id = ID_W'(copy);

    // Only a fresh rising edge can start a frame, and in_ready must have been
    // visible for a full cycle before it, so the source always saw it first.
    always_comb begin
        rise   = bus.en_in & ~en_prev;
        accept = (state == IDLE) && rise && in_ready_q && ready_prev;
        we     = 1'b0;
        wa     = len[AW-1:0];
        if (accept) begin
            we = 1'b1;
            wa = '0;
        end else if (state == LOAD && bus.en_in && len < MAXL) begin
            we = 1'b1;
        end
    end

    frame_buf #(.DEPTH(MAXLEN), .AW(AW)) u_buf (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (bus.data_in),
        .ra  (rd_ptr),
        .rd  (q)
    );

    // rd_ptr runs one ahead of idx so q already holds byte idx in each SEND cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            rd_ptr     <= '0;
            copy       <= '0;
            gcnt       <= '0;
            en_prev    <= 1'b1;
            ready_prev <= 1'b1;
            in_ready_q <= 1'b1;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            en_prev    <= bus.en_in;
            ready_prev <= in_ready_q;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= LOAD;
                        len        <= CW'(1);
                        rd_ptr     <= '0;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.en_in) begin
                        if (len < MAXL) len <= len + CW'(1);
                    end else if (len <= ID_POS) begin
                        state <= IDLE;
                    end else begin
                        state  <= SEND;
                        copy   <= 2'd1;
                        idx    <= '0;
                        rd_ptr <= AW'(1);
                    end
                end
                SEND: begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= (idx == ID_POS) ? {q[7:ID_W], id} : q;
                    idx       <= idx + CW'(1);
                    rd_ptr    <= rd_ptr + AW'(1);
                    if (idx == len - CW'(1)) begin
                        state  <= one2three_pkg::GAP;
                        gcnt   <= '0;
                        rd_ptr <= '0;
                    end
                end
                one2three_pkg::GAP: begin
                    gcnt <= gcnt + GW'(1);
                    if (gcnt == GAP_LAST) begin
                        if (copy < 2'(NCOPY)) begin
                            copy   <= copy + 2'd1;
                            state  <= SEND;
                            idx    <= '0;
                            rd_ptr <= AW'(1);
                        end else begin
                            copy  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.dropped  = (rise && !accept) ||
                          (state == LOAD && !bus.en_in && len <= ID_POS);
endmodule

// File: tb/tb_one2three.sv
// Randomised bench for one2three against a frame-level reference model.
module tb_one2three;
    localparam int WID    = 22;
    localparam int MAXLEN = 4096;
    localparam int GAPC   = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    one2three_if bus();
    one2three #(.WHEREISID(WID), .MAXLEN(MAXLEN), .GAP(GAPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] obs_dat[$];
    int         obs_cyc[$];
    int         drop_cnt = 0;
    int         drop_cyc = -1;
    int         rdy_rise = -1;
    logic       rdy_prev = 1'b1;

    always @(negedge clk) begin
        if (bus.tx_en === 1'b1) begin
            obs_dat.push_back(bus.tx_data);
            obs_cyc.push_back(cyc);
        end
        if (bus.dropped === 1'b1) begin
            drop_cnt++;
            drop_cyc = cyc;
        end
        if (bus.in_ready === 1'b1 && rdy_prev !== 1'b1) rdy_rise = cyc;
        rdy_prev = bus.in_ready;
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] fr[$];
    logic [7:0] exp_q[$];

    task automatic clear_mon();
        obs_dat.delete();
        obs_cyc.delete();
        drop_cnt = 0;
        drop_cyc = -1;
        rdy_rise = -1;
    endtask

    function automatic void mkframe(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
    endfunction

    // Three copies of the first min(n,MAXLEN) bytes, copy number in the low nibble of byte WID.
    function automatic void build_exp();
        int l;
        logic [7:0] b;
        l = (fr.size() > MAXLEN) ? MAXLEN : fr.size();
        exp_q.delete();
        for (int k = 1; k <= 3; k++)
            for (int i = 0; i < l; i++) begin
                b = fr[i];
                if (i == WID) b = {b[7:4], 4'(k)};
                exp_q.push_back(b);
            end
    endfunction

    function automatic int stream_err();
        int n;
        n = (obs_dat.size() > exp_q.size()) ? obs_dat.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= obs_dat.size() || i >= exp_q.size() || obs_dat[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int timing_err(input int t, input int l);
        for (int j = 0; j < obs_cyc.size(); j++)
            if (obs_cyc[j] != t + 2 + (j / l) * (l + GAPC) + (j % l)) return j;
        return -1;
    endfunction

    function automatic int flen();
        return (fr.size() > MAXLEN) ? MAXLEN : fr.size();
    endfunction

    task automatic send_frame(output int first, output int t);
        first = -1;
        for (int i = 0; i < fr.size(); i++) begin
            @(posedge clk); #1;
            bus.en_in   = 1'b1;
            bus.data_in = fr[i];
            if (i == 0) first = cyc;
        end
        @(posedge clk); #1;
        bus.en_in   = 1'b0;
        bus.data_in = 8'h00;
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.en_in = 1'b0; bus.data_in = 8'h00; rst = 1'b0;
        #23;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en got %b want 0", bus.tx_en); end
        tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        tests++; if (bus.dropped !== 1'b0) begin fails++; $display("FAIL reset_dropped got %b want 0", bus.dropped); end
        @(posedge clk); #1; rst = 1'b1;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_inprogress_at_release();
        rst = 1'b0; bus.en_in = 1'b1; bus.data_in = 8'h5A;
        repeat (3) @(posedge clk); #1;
        clear_mon();
        rst = 1'b1;
        repeat (30) begin @(posedge clk); #1; bus.data_in = 8'($urandom_range(0, 255)); end
        bus.en_in = 1'b0;
        repeat (150) @(posedge clk); #5;
        tests++; if (obs_dat.size() != 0) begin fails++; $display("FAIL inprog_tx got %0d bytes want 0", obs_dat.size()); end
        tests++; if (drop_cnt != 0) begin fails++; $display("FAIL inprog_drop got %0d want 0", drop_cnt); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL inprog_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int f, t, l, e;
        clear_mon();
        fr.delete();
        for (int i = 0; i < 60; i++) fr.push_back(8'(i));
        build_exp();
        send_frame(f, t);
        l = flen();
        wait_until(t + 3 * (l + GAPC) + 2); #5;
        e = stream_err();
        tests++; if (e >= 0) begin fails++; $display("FAIL basic_stream first bad idx %0d got %0d bytes want %0d", e, obs_dat.size(), exp_q.size()); end
        tests++; if (obs_dat.size() == 180 && (obs_dat[22] !== 8'h11 || obs_dat[82] !== 8'h12 || obs_dat[142] !== 8'h13))
            begin fails++; $display("FAIL basic_ids got %h %h %h want 11 12 13", obs_dat[22], obs_dat[82], obs_dat[142]); end
        tests++; if (obs_cyc.size() == 0 || obs_cyc[0] != t + 2) begin fails++; $display("FAIL basic_first got %0d want %0d", (obs_cyc.size() != 0) ? obs_cyc[0] - t : -1, 2); end
        e = timing_err(t, l);
        tests++; if (e >= 0) begin fails++; $display("FAIL basic_timing idx %0d got cyc %0d", e, obs_cyc[e] - t); end
        tests++; if (rdy_rise != t + 3 * (l + GAPC) + 2) begin fails++; $display("FAIL basic_ready got %0d want %0d", rdy_rise - t, 3 * (l + GAPC) + 2); end
        tests++; if (drop_cnt != 0) begin fails++; $display("FAIL basic_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_nibble();
        int f, t, l, e;
        clear_mon();
        mkframe($urandom_range(60, 120));
        fr[22] = 8'hA7;
        build_exp();
        send_frame(f, t);
        l = flen();
        wait_until(t + 3 * (l + GAPC) + 2); #5;
        e = stream_err();
        tests++; if (e >= 0) begin fails++; $display("FAIL nibble_stream first bad idx %0d", e); end
        tests++; if (obs_dat.size() == 3 * l && (obs_dat[22] !== 8'hA1 || obs_dat[l + 22] !== 8'hA2 || obs_dat[2 * l + 22] !== 8'hA3))
            begin fails++; $display("FAIL nibble_ids got %h %h %h want a1 a2 a3", obs_dat[22], obs_dat[l + 22], obs_dat[2 * l + 22]); end
    endtask

    task automatic test_short();
        int f, t;
        clear_mon();
        mkframe(WID);
        send_frame(f, t);
        repeat (100) @(posedge clk); #5;
        tests++; if (drop_cnt != 1 || drop_cyc != t) begin fails++; $display("FAIL short_drop got cnt %0d at %0d want 1 at %0d", drop_cnt, drop_cyc, t); end
        tests++; if (obs_dat.size() != 0) begin fails++; $display("FAIL short_tx got %0d bytes want 0", obs_dat.size()); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL short_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_busy();
        int f1, t1, f2, t2, l, e;
        logic [7:0] keep[$];
        clear_mon();
        mkframe(40);
        keep = fr;
        send_frame(f1, t1);
        l = flen();
        repeat (l + GAPC + 4) @(posedge clk); #1;
        mkframe(30);
        send_frame(f2, t2);
        fr = keep;
        build_exp();
        wait_until(t1 + 3 * (l + GAPC) + 2); #5;
        e = stream_err();
        tests++; if (e >= 0) begin fails++; $display("FAIL busy_stream first bad idx %0d got %0d bytes", e, obs_dat.size()); end
        tests++; if (drop_cnt != 1 || drop_cyc != f2) begin fails++; $display("FAIL busy_drop got cnt %0d at %0d want 1 at %0d", drop_cnt, drop_cyc, f2); end
        e = timing_err(t1, l);
        tests++; if (e >= 0) begin fails++; $display("FAIL busy_timing idx %0d", e); end
    endtask

    task automatic test_overflow();
        int f, t, l, e;
        clear_mon();
        mkframe(MAXLEN + 4);
        build_exp();
        send_frame(f, t);
        l = flen();
        wait_until(t + 3 * (l + GAPC) + 2); #5;
        e = stream_err();
        tests++; if (e >= 0) begin fails++; $display("FAIL ovf_stream first bad idx %0d got %0d bytes want %0d", e, obs_dat.size(), exp_q.size()); end
        e = timing_err(t, l);
        tests++; if (e >= 0) begin fails++; $display("FAIL ovf_timing idx %0d", e); end
        tests++; if (rdy_rise != t + 3 * (l + GAPC) + 2) begin fails++; $display("FAIL ovf_ready got %0d want %0d", rdy_rise - t, 3 * (l + GAPC) + 2); end
    endtask

    task automatic test_reset_mid();
        int f, t, l, e;
        clear_mon();
        mkframe(50);
        send_frame(f, t);
        l = flen();
        wait_until(t + 2 + (l + GAPC) + 10);
        rst = 1'b0;
        #4;
        tests++; if (bus.tx_en !== 1'b0) begin fails++; $display("FAIL rstmid_tx_en got %b want 0", bus.tx_en); end
        tests++; if (obs_dat.size() != l + 10) begin fails++; $display("FAIL rstmid_count got %0d want %0d", obs_dat.size(), l + 10); end
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #5;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", bus.in_ready); end
        clear_mon();
        mkframe(40);
        build_exp();
        send_frame(f, t);
        l = flen();
        wait_until(t + 3 * (l + GAPC) + 2); #5;
        e = stream_err();
        tests++; if (e >= 0) begin fails++; $display("FAIL rstmid_stream first bad idx %0d got %0d bytes", e, obs_dat.size()); end
        e = timing_err(t, l);
        tests++; if (e >= 0) begin fails++; $display("FAIL rstmid_timing idx %0d", e); end
    endtask

    // Frames launched at the earliest accepted cycle after in_ready rises.
    task automatic test_back_to_back();
        int f, t, l, e, n;
        for (int r = 0; r < 5; r++) begin
            clear_mon();
            n = (r == 0) ? WID + 1 : $urandom_range(WID + 1, 300);
            mkframe(n);
            build_exp();
            send_frame(f, t);
            l = flen();
            wait_until(t + 3 * (l + GAPC) + 2); #5;
            e = stream_err();
            tests++; if (e >= 0) begin fails++; $display("FAIL b2b%0d_stream len %0d first bad idx %0d", r, n, e); end
            e = timing_err(t, l);
            tests++; if (e >= 0) begin fails++; $display("FAIL b2b%0d_timing idx %0d", r, e); end
            tests++; if (rdy_rise != t + 3 * (l + GAPC) + 2) begin fails++; $display("FAIL b2b%0d_ready got %0d want %0d", r, rdy_rise - t, 3 * (l + GAPC) + 2); end
            tests++; if (drop_cnt != 0) begin fails++; $display("FAIL b2b%0d_drop got %0d want 0", r, drop_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_inprogress_at_release();
        test_basic();
        test_nibble();
        test_short();
        test_busy();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
